seq_det_rr_sched: RTL and testbench
===================================

Name: seq_det_rr_sched

Overview:
- Round-robin scheduler that shares one non-overlapping Moore pattern detector among N_CH requesters.
- Each requester offers a parallel FRAME_LEN-bit frame.
- The scheduler grants one channel, serialises its frame MSB-first into the detector, and counts detections.
- At frame end it reports the match count and the channel ID, then re-arbitrates.
- Sits between the per-channel frame sources and the sequence-detector datapath.

Parameters:
- N_CH, 4, number of requesting channels (>=2)
- FRAME_LEN, 8, bits per frame
- PAT_LEN, 3, pattern length in bits (2..FRAME_LEN)
- PATTERN, 3'b101, pattern to detect, MSB is the first bit received
- CNT_W, 4, match counter width; must satisfy 2^CNT_W-1 >= FRAME_LEN/PAT_LEN

Ports:
- clk  in  1  clock
- rstn  in  1  reset: synchronous, active-low
- req  in  N_CH  per-channel request; frame data must be stable while req is high
- frame_data  in  N_CH*FRAME_LEN  channel c occupies bits [c*FRAME_LEN +: FRAME_LEN]
- grant  out  N_CH  one-hot, one-cycle pulse: frame of that channel accepted
- busy  out  1  high from the SHIFT state through the REPORT state
- det_out  out  1  detector Moore output, for observability
- done  out  1  one-cycle pulse: result valid
- done_ch  out  $clog2(N_CH)  channel of the reported frame, held until the next done
- match_cnt  out  CNT_W  detections in the reported frame, held until the next done

Behaviour:
- Reset: all outputs 0; state IDLE; RR pointer = N_CH-1, so ch0 has first priority; detector cleared. Reset mid-frame aborts with no done.
- States: IDLE, SHIFT, REPORT.
- IDLE:
  - If any req is high, select the first requesting channel searching ptr+1, ptr+2, ... mod N_CH.
  - At that edge: capture the channel's frame into the shift register, set ptr = channel, clear the detector and run counter, go to SHIFT.
  - If no req, stay in IDLE.
- SHIFT (cycles 1..FRAME_LEN after acceptance):
  - grant[ch] is high in SHIFT cycle 1 only.
  - Each cycle feeds the shift register MSB to the detector, then shifts left.
  - After FRAME_LEN bits, go to REPORT.
  - req deasserting during SHIFT has no effect.
  - Requesters must drop req after seeing grant; a still-high req is treated as a new frame.
- REPORT (one cycle):
  - At the end edge, match_cnt = run count + final detector output.
  - The same edge pulses done, sets done_ch, and enters IDLE.
  - done and a new IDLE arbitration coincide, so throughput is one frame per FRAME_LEN+2 cycles.
- Run counter:
  - Increments each cycle det_out=1 during SHIFT cycles 2..FRAME_LEN.
  - Saturates at 2^CNT_W-1.
- Detector (non-overlapping, Moore):
  - Holds a PAT_LEN history register plus a fill count.
  - On each shift-enable cycle it shifts in the bit and increments fill, saturating at PAT_LEN.
  - When fill reaches PAT_LEN and the history equals PATTERN, the registered det_out is 1 on the next cycle, and history and fill clear (no overlap).
  - det_out is otherwise 0.
  - clr forces history, fill and det_out to 0.
  - The detector is idle (det_out=0) when not enabled.
- Latency: req sampled in IDLE at edge E0 → done high in the cycle after edge E0+FRAME_LEN+1.
- Simultaneous requests: exactly one grant per frame, rotating fairly. A channel is never granted twice while another is continuously requesting.

Decomposition:
- Package seq_det_pkg:
  - state enum (IDLE, SHIFT, REPORT)
  - default PATTERN/PAT_LEN constants
  - function next_rr(req, ptr) returning the granted index
- Sub-module nol_pattern_det:
  - Parameters PAT_LEN and PATTERN.
  - Ports clk, rstn, clr, en, bit_in, det_out.
  - Reusable by the other detectors in the family.

Test Plan:
- Single channel: req[0]=1, frame 8'b10101101 → grant=4'b0001 in cycle 1 of SHIFT; done 10 cycles after acceptance; done_ch=0, match_cnt=2 (overlapping would give 3).
- Non-overlap boundaries:
  - 8'b00000000 → match_cnt=0
  - 8'b10110101 → match_cnt=2
  - 8'b10100000 → match_cnt=1
  - 8'b00000101 → match_cnt=1 (final-bit match counted in REPORT)
- Round-robin: all four req held high continuously → grants in order ch0, ch1, ch2, ch3, ch0, with done every 10 cycles and done_ch matching.
- Priority from reset: req=4'b1010 → ch1 first. Then with req=4'b1001, after ptr=1 → ch3 is granted before ch0.
- Reset mid-frame: assert rstn=0 at SHIFT cycle 4 → next cycle all outputs 0, no done, state IDLE. The next frame reports a correct count uncontaminated by the old history.
- Saturation: build with CNT_W=1, PAT_LEN=2, PATTERN=2'b11, frame 8'b11111111 → match_cnt=1 (saturated, not wrapped).

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the sequence-detector scheduler family.
// Provides the FSM state encoding, default pattern constants and round-robin selection.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } state_e;

  localparam int unsigned DEF_PAT_LEN = 3;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 3'b101;

  localparam int unsigned MAX_CH = 32;
  localparam int unsigned MAX_W  = 5;

  // First requester after ptr, wrapping at n_ch; returns ptr if nobody requests.
  function automatic int unsigned next_rr(input logic [MAX_CH-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n_ch);
    int unsigned idx;
    logic        found;
    next_rr = ptr;
    found   = 1'b0;
    for (int unsigned i = 1; i <= n_ch; i++) begin
      idx = ptr + i;
      if (idx >= n_ch) idx = idx - n_ch;
      if (!found && req[idx[MAX_W-1:0]]) begin
        next_rr = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/seq_det_rr_sched_det.sv
// Non-overlapping Moore pattern detector with a fill counter.
// A match clears history so consecutive hits never share bits.
module nol_pattern_det
  import seq_det_pkg::*;
#(
  parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]   PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic det_out
);

  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

  logic [PAT_LEN-1:0] hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
  logic               det_q, det_d;

  assign hist_shift = {hist_q[PAT_LEN-2:0], bit_in};
  assign fill_inc   = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + 1'b1;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = 1'b0;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      if (fill_inc == FILL_W'(PAT_LEN) && hist_shift == PATTERN) begin
        det_d  = 1'b1;
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift;
        fill_d = fill_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
    end
  end

  assign det_out = det_q;

endmodule

// File: rtl/seq_det_rr_sched.sv
// Round-robin scheduler sharing one non-overlapping pattern detector among N_CH frame sources.
// Serialises the granted frame MSB-first and reports its channel and match count.
module seq_det_rr_sched
  import seq_det_pkg::*;
#(
  parameter int unsigned        N_CH      = 4,
  parameter int unsigned        FRAME_LEN = 8,
  parameter int unsigned        PAT_LEN   = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN   = DEF_PATTERN,
  parameter int unsigned        CNT_W     = 4,
  localparam int unsigned       CH_W      = $clog2(N_CH)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_CH-1:0]           req,
  input  logic [N_CH*FRAME_LEN-1:0] frame_data,
  output logic [N_CH-1:0]           grant,
  output logic                      busy,
  output logic                      det_out,
  output logic                      done,
  output logic [CH_W-1:0]           done_ch,
  output logic [CNT_W-1:0]          match_cnt
);

  localparam int unsigned BC_W = $clog2(FRAME_LEN);

  state_e               state_q, state_d;
  logic [CH_W-1:0]      ptr_q, ptr_d, sel;
  logic [FRAME_LEN-1:0] sr_q, sr_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     run_q, run_d;
  logic [N_CH-1:0]      grant_q, grant_d;
  logic                 done_q, done_d;
  logic [CH_W-1:0]      done_ch_q, done_ch_d;
  logic [CNT_W-1:0]     match_cnt_q, match_cnt_d;
  logic                 det_clr, det_en, det_w;

  assign sel = CH_W'(next_rr(MAX_CH'(req), 32'(ptr_q), N_CH));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    run_d       = run_q;
    grant_d     = '0;
    done_d      = 1'b0;
    done_ch_d   = done_ch_q;
    match_cnt_d = match_cnt_q;
    det_clr     = 1'b0;
    det_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          sr_d         = frame_data[32'(sel)*FRAME_LEN +: FRAME_LEN];
          ptr_d        = sel;
          bit_cnt_d    = '0;
          run_d        = '0;
          det_clr      = 1'b1;
          grant_d[sel] = 1'b1;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        det_en = 1'b1;
        sr_d   = {sr_q[FRAME_LEN-2:0], 1'b0};
        if (det_w && run_q != '1) run_d = run_q + 1'b1;
        if (bit_cnt_q == BC_W'(FRAME_LEN - 1)) state_d = REPORT;
        else bit_cnt_d = bit_cnt_q + 1'b1;
      end
      REPORT: begin
        // The last bit's detection only becomes visible here, so fold it in.
        match_cnt_d = (det_w && run_q != '1) ? run_q + 1'b1 : run_q;
        done_d      = 1'b1;
        done_ch_d   = ptr_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= CH_W'(N_CH - 1);
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      run_q       <= '0;
      grant_q     <= '0;
      done_q      <= 1'b0;
      done_ch_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      run_q       <= run_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      done_ch_q   <= done_ch_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  nol_pattern_det #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_det (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (det_clr),
    .en      (det_en),
    .bit_in  (sr_q[FRAME_LEN-1]),
    .det_out (det_w)
  );

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign det_out   = det_w;
  assign done      = done_q;
  assign done_ch   = done_ch_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_det_rr_sched.sv
// Directed scoreboard bench for seq_det_rr_sched: arbitration order, frame counts,
// latency, mid-frame reset and counter saturation (second instance).
module tb_seq_det_rr_sched;

  logic        clk;
  logic        rstn;
  logic [3:0]  req, req_s;
  logic [7:0]  frames [4];
  logic [31:0] frame_data;
  logic [31:0] frame_data_s;
  logic [3:0]  grant, grant_s;
  logic        busy, busy_s, det_out, det_out_s, done, done_s;
  logic [1:0]  done_ch, done_ch_s;
  logic [3:0]  match_cnt;
  logic [0:0]  match_cnt_s;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int last_done = 0;

  typedef struct {
    int ch;
    int cnt;
  } exp_t;
  exp_t sb[$];

  assign frame_data   = {frames[3], frames[2], frames[1], frames[0]};
  assign frame_data_s = {24'h0, 8'hFF};

  seq_det_rr_sched #(
    .N_CH(4), .FRAME_LEN(8), .PAT_LEN(3), .PATTERN(3'b101), .CNT_W(4)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .frame_data(frame_data),
    .grant(grant), .busy(busy), .det_out(det_out), .done(done),
    .done_ch(done_ch), .match_cnt(match_cnt)
  );

  seq_det_rr_sched #(
    .N_CH(4), .FRAME_LEN(8), .PAT_LEN(2), .PATTERN(2'b11), .CNT_W(1)
  ) dut_sat (
    .clk(clk), .rstn(rstn), .req(req_s), .frame_data(frame_data_s),
    .grant(grant_s), .busy(busy_s), .det_out(det_out_s), .done(done_s),
    .done_ch(done_ch_s), .match_cnt(match_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Greedy leftmost non-overlapping scan, MSB first.
  function automatic int count_nol(input logic [7:0] f, input logic [2:0] pat, input int plen);
    int i, n;
    bit ok;
    logic [7:0] w;
    logic [2:0] pw;
    i = 0;
    n = 0;
    while (i + plen <= 8) begin
      ok = 1'b1;
      for (int k = 0; k < plen; k++) begin
        w  = f << (i + k);
        pw = pat << (3 - plen + k);
        if (w[7] !== pw[2]) ok = 1'b0;
      end
      if (ok) begin
        n++;
        i += plen;
      end else begin
        i++;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame_txn(input int exp_ch, input logic [3:0] req_after, input bit chk_period);
    exp_t e;
    int   n;
    e.ch  = exp_ch;
    e.cnt = count_nol(frames[exp_ch], 3'b101, 3);
    sb.push_back(e);
    n = 0;
    while (grant === 4'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("grant", 32'(grant), 32'(4'b0001 << exp_ch));
    check("busy_shift", 32'(busy), 32'd1);
    req = req_after;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 30);
    check("latency", 32'(n), 32'd9);
    if (chk_period) check("period", 32'(cyc - last_done), 32'd10);
    last_done = cyc;
    e = sb.pop_front();
    check("done_ch", 32'(done_ch), 32'(e.ch));
    check("match_cnt", 32'(match_cnt), 32'(e.cnt));
    check("busy_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_det"}, 32'(det_out), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_done_ch"}, 32'(done_ch), 32'd0);
    check({tag, "_match_cnt"}, 32'(match_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] bnd [5];
    int n;
    bit seen;
    bnd[0] = 8'b10101101; bnd[1] = 8'b00000000; bnd[2] = 8'b10110101;
    bnd[3] = 8'b10100000; bnd[4] = 8'b00000101;
    frames[0] = 8'b10101101; frames[1] = 8'b10110101;
    frames[2] = 8'b10100000; frames[3] = 8'b00000101;
    rstn  = 1'b0;
    req   = '0;
    req_s = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_sat_busy", 32'(busy_s), 32'd0);
    check("reset_sat_det", 32'(det_out_s), 32'd0);

    // Priority from reset, then rotation past ptr=1.
    rstn = 1'b1;
    req  = 4'b1010;
    frame_txn(1, 4'b1001, 1'b0);
    frame_txn(3, 4'b0001, 1'b0);
    frame_txn(0, 4'b0000, 1'b0);

    // Single-channel boundary frames on ch0.
    for (int i = 0; i < 5; i++) begin
      frames[0] = bnd[i];
      @(negedge clk);
      req = 4'b0001;
      frame_txn(0, 4'b0000, 1'b0);
    end

    // Mid-frame reset: history 010 would turn the next frame's leading 1 into a false hit.
    frames[0] = 8'b01010000;
    @(negedge clk);
    req = 4'b0001;
    n = 0;
    while (grant === 4'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("abort_grant", 32'(grant), 32'd1);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rstn = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    frames[0] = 8'b10000000;
    req = 4'b0001;
    frame_txn(0, 4'b0000, 1'b0);

    // Continuous requests from reset: ch0..ch3 then ch0 again, one done per 10 cycles.
    frames[0] = 8'b10101101;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    req  = 4'b1111;
    frame_txn(0, 4'b1111, 1'b0);
    frame_txn(1, 4'b1111, 1'b1);
    frame_txn(2, 4'b1111, 1'b1);
    frame_txn(3, 4'b1111, 1'b1);
    frame_txn(0, 4'b0000, 1'b1);

    // Saturating counter: four hits of 11 into a 1-bit count.
    req_s = 4'b0001;
    n = 0;
    while (grant_s === 4'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("sat_grant", 32'(grant_s), 32'd1);
    req_s = 4'b0000;
    n = 0;
    while (done_s !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    n = count_nol(8'hFF, 3'b011, 2);
    if (n > 1) n = 1;
    check("sat_match_cnt", 32'(match_cnt_s), 32'(n));
    check("sat_done_ch", 32'(done_ch_s), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
